multicycle_control: RTL and testbench

Moore-style main control FSM for the multicycle MIPS-subset CPU. It sequences the shared datapath one micro-step per clock: fetch, decode, execute, memory, writeback. It drives every register and memory enable plus the mux selects, and exports the 4-bit state to the top-level STATE port. It sits between the instruction register opcode field and the datapath, and handles wait states on the unified instruction/data memory.

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_next_state.sv | 49 ++++
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle control FSM.
//   - 4-bit state codes (FETCH..HALT); codes 13-15 are unused.
//   - Opcode values for the supported MIPS subset (IR[31:26]).
//   - Encodings for the ALUSrcB, ALUOp and PCSource mux selects.
package mc_pkg;

    // State codes; these values appear directly on the STATE port.
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] RWB    = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;
    localparam logic [3:0] ADDIEX = 4'd10;
    localparam logic [3:0] ADDIWB = 4'd11;
    localparam logic [3:0] HALT   = 4'd12;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU B input select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_next_state.sv
// mc_next_state: purely combinational next-state function of the
// multicycle control FSM.
//   state      in   current state code
//   opcode     in   IR[31:26]
//   mem_ready  in   unified memory finished the current access
//   next_state out  state to load on the next rising edge
module mc_next_state
    import mc_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] next_state
);

    always_comb begin
        next_state = FETCH;
        case (state)
            // Memory-access states hold until the memory completes.
            FETCH:  next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:       next_state = EXEC;
                    OP_LW, OP_SW:   next_state = MEMADR;
                    OP_BEQ, OP_BNE: next_state = BRANCH;
                    OP_J:           next_state = JUMP;
                    OP_ADDI:        next_state = ADDIEX;
                    default:        next_state = HALT;
                endcase
            end
            MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next_state = mem_ready ? MEMWB : MEMRD;
            MEMWB:  next_state = FETCH;
            MEMWR:  next_state = mem_ready ? FETCH : MEMWR;
            EXEC:   next_state = RWB;
            RWB:    next_state = FETCH;
            BRANCH: next_state = FETCH;
            JUMP:   next_state = FETCH;
            ADDIEX: next_state = ADDIWB;
            ADDIWB: next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore main control FSM for the multicycle MIPS-subset
// CPU. Holds the state register and decodes datapath controls from it.
//   clk, rst            clock; synchronous active-high reset
//   OPCODE              IR[31:26]
//   mem_ready           unified memory access complete
//   STATE               current state (0 while rst is high)
//   PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
//                       datapath enables and mux selects
//   illegal             high while halted on an unsupported opcode
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    OPCODE,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] STATE,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] cur_state;

    mc_next_state #(
        .OP_W    (OP_W),
        .STATE_W (STATE_W)
    ) u_next_state (
        .state      (state_q),
        .opcode     (OPCODE),
        .mem_ready  (mem_ready),
        .next_state (state_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // While rst is high the FSM presents as FETCH, so STATE reads 0 even
    // before the first reset edge has loaded the register.
    assign cur_state = rst ? FETCH : state_q;
    assign STATE     = cur_state;

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        ALUOp         = ALUOP_ADD;
        PCSource      = PCSRC_ALU;
        illegal       = 1'b0;

        case (cur_state)
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                // Gate the loads during a stall so PC+4 is taken once.
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            DECODE: begin
                ALUSrcB  = SRCB_IMM_SH;
            end
            MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
            end
            MEMRD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_FUNCT;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALUOP_SUB;
                PCSource      = PCSRC_ALUOUT;
                PCWriteCond   = (OPCODE == OP_BEQ);
                PCWriteCondNE = (OPCODE == OP_BNE);
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            ADDIEX: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            HALT: begin
                illegal  = 1'b1;
            end
            default: begin
            end
        endcase

        if (rst) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            PCWriteCondNE = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Outputs are sampled on the falling
// edge (or 1 time unit after a combinational input change).
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OPCODE;
    logic       mem_ready;
    logic [3:0] STATE;
    logic       PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(.OP_W(6), .STATE_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .OPCODE        (OPCODE),
        .mem_ready     (mem_ready),
        .STATE         (STATE),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .PCSource      (PCSource),
        .illegal       (illegal)
    );

    // Control vector, MSB first:
    // PCW PCWC PCWCNE IorD MR MW IRW M2R RDst RW ASA | ASB[1:0] | AOp[1:0] | PCS[1:0] | ill
    logic [17:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
                  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, illegal};

    // Enables only: PCW PCWC PCWCNE MR MW IRW RW
    logic [6:0] en;
    assign en = {PCWrite, PCWriteCond, PCWriteCondNE, MemRead, MemWrite, IRWrite, RegWrite};

    //                                 PPPIMMIMRRA ASB AOP PCS I
    localparam logic [17:0] V_FETCH  = 18'b10001010000_01_00_00_0;
    localparam logic [17:0] V_FSTALL = 18'b00001000000_01_00_00_0;
    localparam logic [17:0] V_DECODE = 18'b00000000000_11_00_00_0;
    localparam logic [17:0] V_MEMADR = 18'b00000000001_10_00_00_0;
    localparam logic [17:0] V_MEMRD  = 18'b00011000000_00_00_00_0;
    localparam logic [17:0] V_MEMWB  = 18'b00000001010_00_00_00_0;
    localparam logic [17:0] V_MEMWR  = 18'b00010100000_00_00_00_0;
    localparam logic [17:0] V_EXEC   = 18'b00000000001_00_10_00_0;
    localparam logic [17:0] V_RWB    = 18'b00000000110_00_00_00_0;
    localparam logic [17:0] V_BNE    = 18'b00100000001_00_01_01_0;
    localparam logic [17:0] V_BEQ    = 18'b01000000001_00_01_01_0;
    localparam logic [17:0] V_JUMP   = 18'b10000000000_00_00_10_0;
    localparam logic [17:0] V_ADDIEX = 18'b00000000001_10_00_00_0;
    localparam logic [17:0] V_ADDIWB = 18'b00000000010_00_00_00_0;
    localparam logic [17:0] V_HALT   = 18'b00000000000_00_00_00_1;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check STATE and the full control vector together.
    task automatic check_step(input string tag, input logic [3:0] exp_state,
                              input logic [17:0] exp_ctl);
        check({tag, ".state"}, {14'd0, STATE}, {14'd0, exp_state});
        check({tag, ".ctl"}, ctl, exp_ctl);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        OPCODE    = 6'b000000;
        mem_ready = 1'b1;

        // Reset
        @(posedge clk);
        tick();
        check("rst.state", {14'd0, STATE}, 18'd0);
        check("rst.en", {11'd0, en}, 18'd0);
        rst = 1'b0;

        // addi: 0,1,10,11
        OPCODE = 6'b001000;
        #1 check_step("addi.fetch", 4'd0, V_FETCH);
        tick(); check_step("addi.decode", 4'd1, V_DECODE);
        tick(); check_step("addi.ex", 4'd10, V_ADDIEX);
        tick(); check_step("addi.wb", 4'd11, V_ADDIWB);

        // lw: 0,1,2,3,4
        tick(); OPCODE = 6'b100011;
        check_step("lw.fetch", 4'd0, V_FETCH);
        tick(); check_step("lw.decode", 4'd1, V_DECODE);
        tick(); check_step("lw.memadr", 4'd2, V_MEMADR);
        tick(); check_step("lw.memrd", 4'd3, V_MEMRD);
        tick(); check_step("lw.memwb", 4'd4, V_MEMWB);

        // bne: 0,1,8
        tick(); OPCODE = 6'b000101;
        check_step("bne.fetch", 4'd0, V_FETCH);
        tick(); check_step("bne.decode", 4'd1, V_DECODE);
        tick(); check_step("bne.branch", 4'd8, V_BNE);

        // beq: 0,1,8
        tick(); OPCODE = 6'b000100;
        check_step("beq.fetch", 4'd0, V_FETCH);
        tick(); check_step("beq.decode", 4'd1, V_DECODE);
        tick(); check_step("beq.branch", 4'd8, V_BEQ);

        // j: 0,1,9
        tick(); OPCODE = 6'b000010;
        check_step("j.fetch", 4'd0, V_FETCH);
        tick(); check_step("j.decode", 4'd1, V_DECODE);
        tick(); check_step("j.jump", 4'd9, V_JUMP);

        // R-type: 0,1,6,7
        tick(); OPCODE = 6'b000000;
        check_step("r.fetch", 4'd0, V_FETCH);
        tick(); check_step("r.decode", 4'd1, V_DECODE);
        tick(); check_step("r.exec", 4'd6, V_EXEC);
        tick(); check_step("r.rwb", 4'd7, V_RWB);
        OPCODE    = 6'b101011;
        mem_ready = 1'b0;

        // sw with a 2-cycle fetch stall, then a 3-cycle write stall
        tick(); check_step("sw.fstall0", 4'd0, V_FSTALL);
        tick(); check_step("sw.fstall1", 4'd0, V_FSTALL);
        mem_ready = 1'b1;
        #1 check_step("sw.fetch", 4'd0, V_FETCH);
        tick(); check_step("sw.decode", 4'd1, V_DECODE);
        tick(); check_step("sw.memadr", 4'd2, V_MEMADR);
        mem_ready = 1'b0;
        tick(); check_step("sw.wr0", 4'd5, V_MEMWR);
        tick(); check_step("sw.wr1", 4'd5, V_MEMWR);
        tick(); check_step("sw.wr2", 4'd5, V_MEMWR);
        mem_ready = 1'b1;
        #1 check_step("sw.wr3", 4'd5, V_MEMWR);
        tick(); OPCODE = 6'b111111;
        check_step("sw.done", 4'd0, V_FETCH);

        // Illegal opcode -> HALT, sticky until reset
        tick(); check_step("ill.decode", 4'd1, V_DECODE);
        tick(); check_step("ill.halt0", 4'd12, V_HALT);
        tick(); check_step("ill.halt1", 4'd12, V_HALT);
        tick(); check_step("ill.halt2", 4'd12, V_HALT);
        rst = 1'b1;
        #1 check("ill.rst.state", {14'd0, STATE}, 18'd0);
        check("ill.rst.en", {11'd0, en}, 18'd0);
        tick(); rst = 1'b0; OPCODE = 6'b100011;
        #1 check_step("ill.after_rst", 4'd0, V_FETCH);

        // Reset during lw MEMRD aborts the instruction
        tick(); check_step("lwrst.decode", 4'd1, V_DECODE);
        tick(); check_step("lwrst.memadr", 4'd2, V_MEMADR);
        tick(); check_step("lwrst.memrd", 4'd3, V_MEMRD);
        rst = 1'b1;
        #1 check("lwrst.rst.state", {14'd0, STATE}, 18'd0);
        check("lwrst.rst.en", {11'd0, en}, 18'd0);
        tick();
        check("lwrst.held.regwrite", {17'd0, RegWrite}, 18'd0);
        rst = 1'b0;
        #1 check_step("lwrst.fetch", 4'd0, V_FETCH);
        check("lwrst.fetch.regwrite", {17'd0, RegWrite}, 18'd0);
        tick(); check_step("lwrst.decode2", 4'd1, V_DECODE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
